// File: rtl/if_fetch.sv
// Instruction fetch stage: drives the instruction ROM from a registered PC and buffers
// returned words in a small FIFO that decode drains with a valid/ready handshake.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    // QDEPTH is 2 or 4, so the pointers wrap naturally at their own width.
    localparam int unsigned PW = (QDEPTH > 2) ? 2 : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        queue_q [QDEPTH];
    entry_t        head;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic          ce_q, ce_d;
    logic          full, deq, acc, redirect;

    // Target byte offset is irrelevant: fetches are always word aligned.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^branch_target_i[1:0];

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q;
    assign id_valid_o = (count_q != '0);
    assign head       = queue_q[rd_ptr_q];
    assign id_pc_o    = id_valid_o ? head.pc   : 32'h0;
    assign id_inst_o  = id_valid_o ? head.inst : 32'h0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        full     = (count_q == FULL_CNT);
        deq      = id_valid_o & id_ready_i;
        acc      = ce_q & ~branch_flag_i & (~full | deq);
        redirect = ce_q & branch_flag_i;
        ce_d     = 1'b1;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            // A head consumed this cycle and the flushed tail both simply vanish.
            pc_d     = {branch_target_i[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                pc_d     = pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({acc, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q     <= 1'b0;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ce_q     <= ce_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count gates every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (acc) begin
            queue_q[wr_ptr_q] <= {pc_q, rom_inst_i};
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a reference model queues expected fetches, a monitor
// compares every presented instruction and the per-cycle ROM/decode outputs.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    logic        m_ce;
    logic [31:0] m_pc;
    int          m_cnt;
    bit          checking = 0;

    if_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .id_ready_i      (id_ready_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: mem[i] = i + 1 for word index i.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr >> 2) + 32'd1;
    endfunction

    always_comb rom_inst_i = rom_word(rom_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the effect of the coming clock edge to the model state.
    task automatic model_edge();
        bit deq;
        bit acc;
        deq = (m_cnt != 0) && id_ready_i;
        if (rst) begin
            m_ce  = 1'b0;
            m_pc  = RESET_PC;
            m_cnt = 0;
            exp_q.delete();
        end else if (m_ce && branch_flag_i) begin
            m_pc  = branch_target_i & 32'hFFFF_FFFC;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            acc = m_ce && ((m_cnt < QDEPTH) || deq);
            if (acc) begin
                exp_q.push_back('{m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_cnt = m_cnt + int'(acc) - int'(deq);
            m_ce  = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic br, input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        rst             = r;
        branch_flag_i   = br;
        branch_target_i = tgt;
        id_ready_i      = rdy;
        #2;
        model_edge();
        if (r) checking = 1;
    endtask

    // Monitor: compares the cycle's outputs and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        #1;
        if (checking) begin
            check("rom_ce", 32'(rom_ce_o), 32'(m_ce));
            check("rom_addr", rom_addr_o, m_pc);
            check("id_valid", 32'(id_valid_o), 32'(m_cnt != 0));
            if (!id_valid_o) begin
                check("idle_pc", id_pc_o, 32'h0);
                check("idle_inst", id_inst_o, 32'h0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(id_valid_o), 32'h0);
            end else begin
                check("head_pc", id_pc_o, exp_q[0].pc);
                check("head_inst", id_inst_o, exp_q[0].inst);
                if (id_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic        r;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;

        rst             = 1'b1;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        id_ready_i      = 1'b0;
        m_ce            = 1'b0;
        m_pc            = RESET_PC;
        m_cnt           = 0;

        // Reset release and steady streaming.
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        check("rst_ce", 32'(rom_ce_o), 32'h0);
        check("rst_valid", 32'(id_valid_o), 32'h0);
        step(0, 0, 0, 1);
        check("first_ce", 32'(rom_ce_o), 32'h1);
        check("first_addr", rom_addr_o, RESET_PC);
        check("first_novalid", 32'(id_valid_o), 32'h0);
        step(0, 0, 0, 1);
        check("seq0_pc", id_pc_o, 32'h0);
        check("seq0_inst", id_inst_o, 32'h1);
        step(0, 0, 0, 1);
        check("seq1_pc", id_pc_o, 32'h4);
        check("seq1_inst", id_inst_o, 32'h2);
        step(0, 0, 0, 1);
        check("seq2_pc", id_pc_o, 32'h8);
        check("seq2_inst", id_inst_o, 32'h3);

        // Back-pressure: queue fills and the PC freezes.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        check("stall_addr", rom_addr_o, RESET_PC + 32'(4 * QDEPTH));
        check("stall_head_pc", id_pc_o, 32'h0);
        check("stall_head_inst", id_inst_o, 32'h1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1);

        // Branch with a full queue and decode ready.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0103, 1);
        step(0, 0, 0, 1);
        check("br_valid", 32'(id_valid_o), 32'h0);
        check("br_addr", rom_addr_o, 32'h0000_0100);
        step(0, 0, 0, 1);
        check("br_pc", id_pc_o, 32'h0000_0100);
        check("br_inst", id_inst_o, 32'h0000_0041);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFF8, 1);
        step(0, 0, 0, 1);
        check("wrap_a0", rom_addr_o, 32'hFFFF_FFF8);
        step(0, 0, 0, 1);
        check("wrap_a1", rom_addr_o, 32'hFFFF_FFFC);
        check("wrap_p0", id_pc_o, 32'hFFFF_FFF8);
        step(0, 0, 0, 1);
        check("wrap_a2", rom_addr_o, 32'h0000_0000);
        check("wrap_p1", id_pc_o, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wrap_p2", id_pc_o, 32'h0000_0000);

        // Mid-stream reset with two entries queued.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("pre_rst_full", 32'(id_valid_o), 32'h1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        check("mrst_valid", 32'(id_valid_o), 32'h0);
        check("mrst_ce", 32'(rom_ce_o), 32'h0);
        check("mrst_addr", rom_addr_o, RESET_PC);
        step(0, 0, 0, 1);
        check("restart_addr", rom_addr_o, RESET_PC);
        step(0, 0, 0, 1);
        check("restart_pc", id_pc_o, RESET_PC);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            br  = !r && ($urandom_range(0, 39) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            rdy = ($urandom_range(0, 99) < 60);
            step(r, br, tgt, rdy);
        end
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);

        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
